// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync/de with active-area coordinates,
// plus a look-ahead fetch strobe LEAD enabled cycles ahead of display.
module video_timing_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 62,
  parameter int H_BP     = 60,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 30,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int LEAD     = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geometry
    $error("video_timing_gen: every active/porch/sync parameter must be >= 1");
  end
  if (LEAD < 0 || LEAD > H_FP + H_SYNC + H_BP) begin : g_bad_lead
    $error("video_timing_gen: LEAD must lie in 0..H_FP+H_SYNC+H_BP");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW:0]   H_TOT_W = (HW+1)'(H_TOTAL);
  localparam logic [HW:0]   LEAD_W  = (HW+1)'(LEAD);
  localparam logic          H_ON = (H_POL != 0);
  localparam logic          V_ON = (V_POL != 0);

  logic [HW-1:0] h_q, h_d, fh;
  logic [VW-1:0] v_q, v_d, fv, v_inc;
  logic [HW:0]   fsum;
  logic          active, f_active;

  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q, fetch_req_q;
  logic [HW-1:0] x_q, fetch_x_q;
  logic [VW-1:0] y_q, fetch_y_q;

  always_comb begin
    v_inc  = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    h_d    = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d    = (h_q == H_LAST) ? v_inc : v_q;
    active = (h_q < H_ACT) && (v_q < V_ACT);
    // LEAD never exceeds the blanking width, so at most one line wrap can occur.
    fsum   = {1'b0, h_q} + LEAD_W;
    fh     = fsum[HW-1:0];
    fv     = v_q;
    if (fsum >= H_TOT_W) begin
      fh = HW'(fsum - H_TOT_W);
      fv = v_inc;
    end
    f_active = (fh < H_ACT) && (fv < V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~H_ON;
      vsync_q       <= ~V_ON;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fetch_req_q   <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (en) begin
        h_q           <= h_d;
        v_q           <= v_d;
        // Outputs decode the pre-advance position, keeping every output mutually aligned.
        hsync_q       <= (h_q >= HS_BEG && h_q < HS_END) ? H_ON : ~H_ON;
        vsync_q       <= (v_q >= VS_BEG && v_q < VS_END) ? V_ON : ~V_ON;
        de_q          <= active;
        x_q           <= active ? h_q : '0;
        y_q           <= active ? v_q : '0;
        line_start_q  <= active && (h_q == '0);
        frame_start_q <= (h_q == '0) && (v_q == '0);
        fetch_req_q   <= f_active;
        fetch_x_q     <= f_active ? fh : '0;
        fetch_y_q     <= f_active ? fv : '0;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign fetch_req   = fetch_req_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen in a small 12x7 raster with high-true syncs and LEAD=4.
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int LEAD = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs, vs, de;
    logic [3:0] x;
    logic [2:0] y;
    logic       ls, fs, fr;
    logic [3:0] fx;
    logic [2:0] fy;
  } outs_t;

  typedef struct packed {
    int    pos;
    outs_t o;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       hsync, vsync, de, line_start, frame_start, fetch_req;
  logic [3:0] x, fetch_x;
  logic [2:0] y, fetch_y;

  int n_checks = 0;
  int n_pass   = 0;
  sb_t   q[$];
  int    m_idx;
  outs_t last;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1), .V_POL(1), .LEAD(LEAD)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input bit hs_i, vs_i, de_i, input int x_i, y_i,
                               input bit ls_i, fs_i, fr_i, input int fx_i, fy_i);
    outs_t r;
    r.hs = hs_i; r.vs = vs_i; r.de = de_i; r.x = 4'(x_i); r.y = 3'(y_i);
    r.ls = ls_i; r.fs = fs_i; r.fr = fr_i; r.fx = 4'(fx_i); r.fy = 3'(fy_i);
    return r;
  endfunction

  // Behavioural model on a linear pixel index; look-ahead is just idx+LEAD mod frame.
  function automatic outs_t at_pos(input int idx);
    int h, v, fi, fh, fv;
    bit a, fa;
    h  = idx % HT;  v  = idx / HT;
    fi = (idx + LEAD) % FT;
    fh = fi % HT;   fv = fi / HT;
    a  = (h < HA) && (v < VA);
    fa = (fh < HA) && (fv < VA);
    return mk((h >= HA + HFP) && (h < HA + HFP + HS),
              (v >= VA + VFP) && (v < VA + VFP + VS),
              a, a ? h : 0, a ? v : 0, a && (h == 0), (h == 0) && (v == 0),
              fa, fa ? fh : 0, fa ? fv : 0);
  endfunction

  // Hand-computed vectors at selected raster positions.
  function automatic bit hand(input int pos, output outs_t o);
    hand = 1'b1;
    case (pos)
      0:  o = mk(0, 0, 1, 0, 0, 1, 1, 1, 4, 0);
      7:  o = mk(0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
      8:  o = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      9:  o = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      10: o = mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 1);
      11: o = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
      36: o = mk(0, 0, 1, 0, 3, 1, 0, 1, 4, 3);
      51: o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      60: o = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      71: o = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      72: o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      80: o = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      83: o = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      default: begin o = '0; hand = 1'b0; end
    endcase
  endfunction

  function automatic outs_t dut_outs();
    return {hsync, vsync, de, x, y, line_start, frame_start, fetch_req, fetch_x, fetch_y};
  endfunction

  task automatic compare(input string name, input int tag, input outs_t got, input outs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s tag=%0d got=%h want=%h", name, tag, got, want);
  endtask

  task automatic check_reset(input string name);
    compare(name, -1, dut_outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic step(input bit e);
    sb_t s;
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    if (e) begin
      s.pos = m_idx;
      s.o   = at_pos(m_idx);
      m_idx = (m_idx + 1) % FT;
    end else begin
      s.pos  = -1;
      s.o    = last;
      s.o.ls = 1'b0;
      s.o.fs = 1'b0;
    end
    last = s.o;
    q.push_back(s);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("reset_async");
    @(posedge clk);
    #1 check_reset("reset_hold");
    m_idx = 0;
    last  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per clock once stimulus is running.
  initial begin
    sb_t   s;
    outs_t h;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        s = q.pop_front();
        $display("t=%0t pos=%0d de=%b x=%0d y=%0d hs=%b vs=%b ls=%b fs=%b fr=%b fx=%0d fy=%0d",
                 $time, s.pos, de, x, y, hsync, vsync, line_start, frame_start,
                 fetch_req, fetch_x, fetch_y);
        compare("scoreboard", s.pos, dut_outs(), s.o);
        if (s.pos >= 0 && hand(s.pos, h)) compare("hand_vector", s.pos, dut_outs(), h);
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    m_idx = 0;
    last  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_reset("reset_init");

    for (int i = 0; i < 2 * FT + 5; i++) step(1'b1);
    for (int i = 0; i < 120; i++) step(i % 4 == 0);
    mid_reset();
    for (int i = 0; i < FT + 3; i++) step(1'b1);
    for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got=%0d want=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
